// File: rtl/icache_ctrl_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
// Widths, line count, FSM encodings and the RVC predicate.
// Optional build macro used by this block: ICACHE_C_PREFILL_EN.
package icache_ctrl_pkg;

  localparam int unsigned ADDR_WIDTH  = 32;
  localparam int unsigned INST_WIDTH  = 32;
  localparam int unsigned INDEX_WIDTH = 4;
  localparam int unsigned TAG_WIDTH   = 27;
  localparam int unsigned DEPTH       = 1 << INDEX_WIDTH;

  localparam logic [0:0] ICACHE_IDLE = 1'b0;
  localparam logic [0:0] ICACHE_MISS = 1'b1;

  // Anything whose low two bits are not 2'b11 is a 16-bit instruction.
  function automatic logic is_rvc(input logic [1:0] lo);
    return lo != 2'b11;
  endfunction

endpackage

// File: rtl/icache_ctrl_array.sv
// Line storage for icache_ctrl: valid/tag/data arrays with tag compare.
// Ports: clk, rst_in (async active-low, clears valid only),
//   rd_idx/rd_tag -> hit_c/rd_data_c (combinational lookup),
//   wr_en/wr_idx/wr_tag/wr_data/wr_pc (synchronous fill write).
// ICACHE_C_PREFILL_EN: a fill with a compressed low half also writes the
//   upper half into the line for PC+2, marked as a half line.
module icache_ctrl_array
  import icache_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_in,
  input  logic [INDEX_WIDTH-1:0] rd_idx,
  input  logic [TAG_WIDTH-1:0]   rd_tag,
  output logic                   hit_c,
  output logic [INST_WIDTH-1:0]  rd_data_c,
  input  logic                   wr_en,
  input  logic [INDEX_WIDTH-1:0] wr_idx,
  input  logic [TAG_WIDTH-1:0]   wr_tag,
  input  logic [INST_WIDTH-1:0]  wr_data,
  input  logic [ADDR_WIDTH-1:0]  wr_pc
);

  logic [DEPTH-1:0]      valid;
  logic [TAG_WIDTH-1:0]  tags [DEPTH];
  logic [INST_WIDTH-1:0] data [DEPTH];

  assign rd_data_c = data[rd_idx];

`ifdef ICACHE_C_PREFILL_EN
  logic [DEPTH-1:0]       half;
  logic [ADDR_WIDTH-1:0]  pc2;
  logic [INDEX_WIDTH-1:0] idx2;
  logic [TAG_WIDTH-1:0]   tag2;
  logic                   wr2_en;
  logic                   unused_pc2;

  assign pc2        = wr_pc + ADDR_WIDTH'(2);
  assign idx2       = pc2[INDEX_WIDTH:1];
  assign tag2       = pc2[ADDR_WIDTH-1:INDEX_WIDTH+1];
  assign unused_pc2 = pc2[0];
  // Second write is dropped when PC+2 folds back onto the fill's own line.
  assign wr2_en     = wr_en && is_rvc(wr_data[1:0]) && (idx2 != wr_idx);

  // A half line only holds a usable instruction if that instruction is 16-bit.
  assign hit_c = valid[rd_idx] && (tags[rd_idx] == rd_tag) &&
                 (!half[rd_idx] || is_rvc(data[rd_idx][1:0]));

  // Valid bits: the only reset state in the array.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      valid <= '0;
    end else begin
      if (wr_en)  valid[wr_idx] <= 1'b1;
      if (wr2_en) valid[idx2]   <= 1'b1;
    end
  end

  // Tag/data/half payload, no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
      half[wr_idx] <= 1'b0;
    end
    if (wr2_en) begin
      tags[idx2] <= tag2;
      data[idx2] <= {(INST_WIDTH/2)'(0), wr_data[INST_WIDTH-1:INST_WIDTH/2]};
      half[idx2] <= 1'b1;
    end
  end
`else
  logic unused_wr_pc;

  assign unused_wr_pc = ^wr_pc;
  assign hit_c        = valid[rd_idx] && (tags[rd_idx] == rd_tag);

  // Valid bits: the only reset state in the array.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag/data payload, no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
  end
`endif

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller between ifetch and memory.
// Ports: clk, rst_in (async active-low), rdy_in (global enable), flush;
//   ifetch side: if2cache_en/PC in, cache2if_busy/rdy/inst/PC/is_c out;
//   memory side: cache2mem_upd_en/PC out, mem2cache_upd/idx/tag/PC/inst in.
// Optional build macro: ICACHE_C_PREFILL_EN (handled in icache_ctrl_array).
module icache_ctrl
  import icache_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   flush,
  input  logic                   if2cache_en,
  input  logic [ADDR_WIDTH-1:0]  if2cache_PC,
  output logic                   cache2if_busy,
  output logic                   cache2if_rdy,
  output logic [INST_WIDTH-1:0]  cache2if_inst,
  output logic [ADDR_WIDTH-1:0]  cache2if_PC,
  output logic                   cache2if_is_c,
  output logic                   cache2mem_upd_en,
  output logic [ADDR_WIDTH-1:0]  cache2mem_PC,
  input  logic                   mem2cache_upd,
  input  logic [INDEX_WIDTH-1:0] mem2cache_idx,
  input  logic [TAG_WIDTH-1:0]   mem2cache_tag,
  input  logic [ADDR_WIDTH-1:0]  mem2cache_PC,
  input  logic [INST_WIDTH-1:0]  mem2cache_inst
);

  logic [0:0]            state, state_n;
  logic [ADDR_WIDTH-1:0] miss_pc, miss_pc_n;
  logic                  busy_n, rdy_n, is_c_n, upd_en_n;
  logic [INST_WIDTH-1:0] inst_n;
  logic [ADDR_WIDTH-1:0] pc_n, mem_pc_n;
  logic                  hit_c;
  logic [INST_WIDTH-1:0] rd_data_c;
  logic                  wr_en;
  logic                  unused_pc0;

  assign unused_pc0 = if2cache_PC[0];
  // Fills land even during flush; only rdy_in can hold them off.
  assign wr_en = mem2cache_upd && rdy_in;

  icache_ctrl_array u_array (
    .clk       (clk),
    .rst_in    (rst_in),
    .rd_idx    (if2cache_PC[INDEX_WIDTH:1]),
    .rd_tag    (if2cache_PC[ADDR_WIDTH-1:INDEX_WIDTH+1]),
    .hit_c     (hit_c),
    .rd_data_c (rd_data_c),
    .wr_en     (wr_en),
    .wr_idx    (mem2cache_idx),
    .wr_tag    (mem2cache_tag),
    .wr_data   (mem2cache_inst),
    .wr_pc     (mem2cache_PC)
  );

  // Next state and next output values; reply fields are zero unless delivering.
  always_comb begin
    state_n  = state;
    miss_pc_n = miss_pc;
    busy_n   = cache2if_busy;
    upd_en_n = cache2mem_upd_en;
    mem_pc_n = cache2mem_PC;
    rdy_n    = 1'b0;
    inst_n   = '0;
    pc_n     = '0;
    is_c_n   = 1'b0;
    if (flush) begin
      state_n  = ICACHE_IDLE;
      busy_n   = 1'b0;
      upd_en_n = 1'b0;
    end else begin
      case (state)
        ICACHE_IDLE: begin
          if (if2cache_en) begin
            if (hit_c) begin
              rdy_n  = 1'b1;
              inst_n = rd_data_c;
              pc_n   = if2cache_PC;
              is_c_n = is_rvc(rd_data_c[1:0]);
            end else begin
              state_n   = ICACHE_MISS;
              miss_pc_n = if2cache_PC;
              busy_n    = 1'b1;
              upd_en_n  = 1'b1;
              mem_pc_n  = if2cache_PC;
            end
          end
        end
        ICACHE_MISS: begin
          // Stale fills are written by the array but do not end the miss.
          if (mem2cache_upd && (mem2cache_PC == miss_pc)) begin
            state_n  = ICACHE_IDLE;
            busy_n   = 1'b0;
            upd_en_n = 1'b0;
            rdy_n    = 1'b1;
            inst_n   = mem2cache_inst;
            pc_n     = mem2cache_PC;
            is_c_n   = is_rvc(mem2cache_inst[1:0]);
          end
        end
        default: state_n = ICACHE_IDLE;
      endcase
    end
  end

  // State and output registers, frozen while rdy_in is low.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state            <= ICACHE_IDLE;
      miss_pc          <= '0;
      cache2if_busy    <= 1'b0;
      cache2if_rdy     <= 1'b0;
      cache2if_inst    <= '0;
      cache2if_PC      <= '0;
      cache2if_is_c    <= 1'b0;
      cache2mem_upd_en <= 1'b0;
      cache2mem_PC     <= '0;
    end else if (rdy_in) begin
      state            <= state_n;
      miss_pc          <= miss_pc_n;
      cache2if_busy    <= busy_n;
      cache2if_rdy     <= rdy_n;
      cache2if_inst    <= inst_n;
      cache2if_PC      <= pc_n;
      cache2if_is_c    <= is_c_n;
      cache2mem_upd_en <= upd_en_n;
      cache2mem_PC     <= mem_pc_n;
    end
  end

endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Direct-mapped instruction cache between ifetch (upstream requester) and the memory controller (refill source).
- Serves hits in one cycle.
- On a miss, holds the refill request to the memory controller until the filled word returns, writes the line, then replies to ifetch.
- Flags RVC (compressed) instructions for ifetch.

Parameters:
- ADDR_WIDTH, 32, PC width.
- INST_WIDTH, 32, instruction word width.
- INDEX_WIDTH, 4, line index bits = PC[4:1]; depth = 2**INDEX_WIDTH (16).
- TAG_WIDTH, 27, tag bits = PC[31:5].

Ports:
- clk  in  1  clock, rising edge.
- rst_in  in  1  asynchronous, active-low reset.
- rdy_in  in  1  global enable; low freezes all state.
- flush  in  1  pipeline flush (branch mispredict).
- if2cache_en  in  1  fetch request valid.
- if2cache_PC  in  ADDR_WIDTH  fetch PC; bit0 is always 0.
- cache2if_busy  out  1  high while in MISS; ifetch must not request.
- cache2if_rdy  out  1  one-cycle pulse: instruction valid.
- cache2if_inst  out  INST_WIDTH  fetched word.
- cache2if_PC  out  ADDR_WIDTH  PC of the delivered word.
- cache2if_is_c  out  1  cache2if_inst[1:0] != 2'b11.
- cache2mem_upd_en  out  1  refill request level, held until fill.
- cache2mem_PC  out  ADDR_WIDTH  refill PC.
- mem2cache_upd  in  1  fill strobe, one cycle.
- mem2cache_idx  in  INDEX_WIDTH  fill index.
- mem2cache_tag  in  TAG_WIDTH  fill tag.
- mem2cache_PC  in  ADDR_WIDTH  fill PC.
- mem2cache_inst  in  INST_WIDTH  fill data; valid when mem2cache_upd is high.

Behaviour:
- Storage: valid[D], tag[D][TAG_WIDTH], data[D][INST_WIDTH].
  - Reset clears valid only.
  - flush does not clear valid.
- Reset values: all outputs 0; state IDLE; miss_PC 0.
- FSM states: IDLE, MISS.
- IDLE, request with if2cache_en=1:
  - Lookup index = PC[4:1], tag = PC[31:5].
  - Hit: next cycle cache2if_rdy=1, with cache2if_inst = data[idx] and cache2if_PC = PC. Hit latency is 1 cycle.
  - Miss: latch miss_PC; go to MISS. Next cycle cache2mem_upd_en=1 and cache2mem_PC=miss_PC.
- MISS:
  - Hold upd_en and cache2mem_PC stable; cache2if_busy=1.
  - Memory-side stalls while LSB traffic is served are absorbed; no timeout.
- Fill (mem2cache_upd=1, any state):
  - Write valid/tag/data at mem2cache_idx in that cycle.
  - If in MISS and mem2cache_PC == miss_PC: next cycle cache2if_rdy=1 with the fill data and PC; drop upd_en in the same cycle as rdy; go to IDLE.
  - Fill PC mismatch (stale fill): write the line; stay in MISS.
- cache2if_rdy is a single-cycle pulse; outputs return to 0 the cycle after.
- flush:
  - Has priority over everything except the fill write.
  - Next cycle: state IDLE, upd_en=0, rdy=0.
  - A fill arriving in the flush cycle is still written but produces no reply.
  - if2cache_en in the flush cycle is ignored.
- if2cache_en while busy is ignored; this is a protocol violation and the bench asserts on it.
- rdy_in=0: no state, array or output register changes.
- Reset mid-MISS: immediate return to IDLE, upd_en=0, all lines invalid.
- Aliasing: PC and PC+32 share an index; a fill replaces the line (no victim handling).

Optional Feature:
- Macro: ICACHE_C_PREFILL_EN.
- Enabled:
  - Each line carries a half bit.
  - When a fill's low halfword is compressed, also write line idx(PC+2) with tag(PC+2), data = {16'b0, fill[31:16]}, half=1.
  - Skip that extra write if it targets the same index as the fill itself.
  - A lookup hits a half line only if its stored [1:0] != 2'b11; otherwise it misses.
- Disabled: single write per fill; half bit absent.

Decomposition:
- Shared include (util.v defines): ADDR_WIDTH, INST_WIDTH, INDEX_WIDTH, TAG_WIDTH macros; FSM state encodings ICACHE_IDLE, ICACHE_MISS.
- Sub-module icache_array:
  - Valid/tag/data storage plus tag-compare.
  - Combinational read port returns hit and data.
  - Synchronous write port; async clear on rst_in.
  - Instantiated once; the controller FSM stays in icache_ctrl.

Test Plan:
- Cold miss: reset, req PC=0x100 -> upd_en=1 with PC 0x100 from next cycle; fill 0x00A00093 after 4 cycles -> rdy pulse 1 cycle later, inst 0x00A00093, is_c=0.
- Warm hit: re-request 0x100 -> rdy exactly 1 cycle later with same data; upd_en stays 0.
- Conflict: fill 0x100, then req 0x120 (same idx 0) -> miss; after fill, req 0x100 misses again.
- Flush mid-miss: req 0x200, flush 2 cycles later -> upd_en 0 next cycle, no rdy; late fill of 0x200 in the flush cycle is written; subsequent req 0x200 hits.
- Compressed: fill at 0x300 with 0x45014505 -> is_c=1. With ICACHE_C_PREFILL_EN, req 0x302 hits with inst[15:0]=0x4501; without it, req 0x302 misses.
- rdy_in low during hit response cycle -> rdy deferred until rdy_in returns; data unchanged.
